// File: rtl/vga_digit_writer_pkg.sv
// -----------------------------------------------------------------------------
// vga_digit_writer_pkg
// Shared definitions for the VGA digit writer: FSM state encoding and the
// largest value that the two-digit display can show.
// -----------------------------------------------------------------------------
package vga_digit_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_T  = 2'd1,
        CONV_S  = 2'd2,
        WAIT_VB = 2'd3
    } state_t;

    // Two decimal digits per value.
    localparam int DIGIT_MAX = 99;

endpackage

// File: rtl/vga_digit_writer_if.sv
// -----------------------------------------------------------------------------
// vga_digit_writer_if
// Load handshake between the refrigeration control FSM (master) and the
// digit writer (slave).
//   load_valid   master -> slave  new value set offered
//   load_ready   slave  -> master writer idle; transfer = valid & ready
//   temp_bin     master -> slave  measured temperature, binary
//   set_bin      master -> slave  setpoint, binary
//   status_code  master -> slave  status glyph code
// -----------------------------------------------------------------------------
interface vga_digit_writer_if #(
    parameter int BIN_W = 7
);
    logic             load_valid;
    logic             load_ready;
    logic [BIN_W-1:0] temp_bin;
    logic [BIN_W-1:0] set_bin;
    logic [3:0]       status_code;

    modport master (
        output load_valid,
        output temp_bin,
        output set_bin,
        output status_code,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  temp_bin,
        input  set_bin,
        input  status_code,
        output load_ready
    );
endinterface

// File: rtl/vga_digit_writer_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one iteration per clock.
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   start  in   loads bin and performs the first iteration on the same edge
//   bin    in   binary value, must be <= 99
//   busy   out  further iterations still pending after the start edge
//   tens   out  BCD tens digit (holds the last result while idle)
//   units  out  BCD units digit
// A conversion takes BIN_W edges: the start edge plus BIN_W-1 more.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    // 8 bits of BCD above the binary shift field.
    localparam int SR_W  = 8 + BIN_W;
    localparam int REM_W = $clog2(BIN_W) + 1;

    logic [SR_W-1:0]  r_sr;
    logic [REM_W-1:0] r_rem;

    // One double-dabble iteration: correct each BCD nibble, then shift.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] v;
        v = sr;
        if (v[SR_W-1 -: 4] >= 4'd5)
            v[SR_W-1 -: 4] = v[SR_W-1 -: 4] + 4'd3;
        if (v[SR_W-5 -: 4] >= 4'd5)
            v[SR_W-5 -: 4] = v[SR_W-5 -: 4] + 4'd3;
        return v << 1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= '0;
            r_rem <= '0;
        end else if (start) begin
            r_sr  <= dabble_step({8'd0, bin});
            r_rem <= REM_W'(BIN_W - 1);
        end else if (r_rem != '0) begin
            r_sr  <= dabble_step(r_sr);
            r_rem <= r_rem - 1'b1;
        end
    end

    assign busy  = (r_rem != '0);
    assign tens  = r_sr[SR_W-1 -: 4];
    assign units = r_sr[SR_W-5 -: 4];

endmodule

// File: rtl/vga_digit_writer.sv
// -----------------------------------------------------------------------------
// vga_digit_writer
// Converts temperature and setpoint to BCD and publishes them, together with
// the status code, as five 4-bit digit registers for the VGA text renderer.
// All digits change together on the first vsync falling edge after the
// conversion finishes (or after TIMEOUT cycles without one).
//   clk          in   system clock (same as hvsync_generator)
//   rst          in   asynchronous active-low reset
//   load_if      slave handshake: load_valid/load_ready, temp_bin, set_bin,
//                status_code
//   vga_v_sync   in   vertical sync, active low
//   registrotd   out  temperature tens digit
//   registrotu   out  temperature units digit
//   registrosd   out  setpoint tens digit
//   registrosu   out  setpoint units digit
//   registrosc   out  status code
//   saturated    out  an input of the last committed set was clamped to 99
//   done         out  1-cycle pulse on the cycle the digits change
// -----------------------------------------------------------------------------
module vga_digit_writer
    import vga_digit_writer_pkg::*;
#(
    parameter int BIN_W   = 7,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_digit_writer_if.slave    load_if,
    input  logic                 vga_v_sync,
    output logic [3:0]           registrotd,
    output logic [3:0]           registrotu,
    output logic [3:0]           registrosd,
    output logic [3:0]           registrosu,
    output logic [3:0]           registrosc,
    output logic                 saturated,
    output logic                 done
);

    localparam int               CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [BIN_W-1:0] CLAMP = BIN_W'(DIGIT_MAX);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vs_q;

    logic [BIN_W-1:0] r_temp, r_set;
    logic [3:0]       r_sc;
    logic             r_sat_t, r_sat_s;
    logic [3:0]       r_sh_td, r_sh_tu;

    logic [3:0]       r_td, r_tu, r_sd, r_su, r_sc_out;
    logic             r_sat, r_done;

    logic             w_transfer, w_vsync_fall, w_start, w_step;
    logic             w_conv_last, w_commit, w_busy;
    logic [BIN_W-1:0] w_bin;
    logic [3:0]       w_tens, w_units;

    assign load_if.load_ready = (r_state == IDLE);
    assign w_transfer   = load_if.load_valid & load_if.load_ready;
    assign w_vsync_fall = r_vs_q & ~vga_v_sync;

    // The step counter shares r_cnt: it restarts at 0 for each value, and the
    // converter is kicked on the first cycle of CONV_T and of CONV_S.
    assign w_start     = ((r_state == CONV_T) || (r_state == CONV_S)) && (r_cnt == '0);
    assign w_step      = w_start | w_busy;
    assign w_conv_last = (r_cnt == CNT_W'(BIN_W - 1));
    assign w_bin       = (r_state == CONV_T) ? r_temp : r_set;
    assign w_commit    = (r_state == WAIT_VB) &&
                         (w_vsync_fall || (r_cnt == CNT_W'(TIMEOUT - 1)));

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_bin),
        .busy  (w_busy),
        .tens  (w_tens),
        .units (w_units)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_transfer)             w_next = CONV_T;
            CONV_T:  if (w_step && w_conv_last)  w_next = CONV_S;
            CONV_S:  if (w_step && w_conv_last)  w_next = WAIT_VB;
            WAIT_VB: if (w_commit)               w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_vs_q  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_vs_q  <= vga_v_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_transfer) begin
            r_cnt <= '0;
        end else if ((r_state == CONV_T) || (r_state == CONV_S)) begin
            if (w_step)
                r_cnt <= w_conv_last ? '0 : r_cnt + 1'b1;
        end else if (r_state == WAIT_VB) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Capture clamped inputs and their clamp flags at the transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_temp  <= '0;
            r_set   <= '0;
            r_sc    <= '0;
            r_sat_t <= 1'b0;
            r_sat_s <= 1'b0;
        end else if (w_transfer) begin
            r_sat_t <= (load_if.temp_bin > CLAMP);
            r_sat_s <= (load_if.set_bin > CLAMP);
            r_temp  <= (load_if.temp_bin > CLAMP) ? CLAMP : load_if.temp_bin;
            r_set   <= (load_if.set_bin > CLAMP) ? CLAMP : load_if.set_bin;
            r_sc    <= load_if.status_code;
        end
    end

    // Temperature result is parked here when the converter is restarted for
    // the setpoint; the setpoint result stays in the converter until commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_td <= '0;
            r_sh_tu <= '0;
        end else if ((r_state == CONV_S) && w_start) begin
            r_sh_td <= w_tens;
            r_sh_tu <= w_units;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_td     <= '0;
            r_tu     <= '0;
            r_sd     <= '0;
            r_su     <= '0;
            r_sc_out <= '0;
            r_sat    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_td     <= r_sh_td;
                r_tu     <= r_sh_tu;
                r_sd     <= w_tens;
                r_su     <= w_units;
                r_sc_out <= r_sc;
                r_sat    <= r_sat_t | r_sat_s;
            end
        end
    end

    assign registrotd = r_td;
    assign registrotu = r_tu;
    assign registrosd = r_sd;
    assign registrosu = r_su;
    assign registrosc = r_sc_out;
    assign saturated  = r_sat;
    assign done       = r_done;

endmodule

// File: tb/tb_vga_digit_writer.sv
module tb_vga_digit_writer;

    localparam int BIN_W   = 7;
    localparam int TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vsync = 1'b1;
    logic [3:0] td, tu, sd, su, sc;
    logic sat, done;

    always #5 clk = ~clk;

    vga_digit_writer_if #(.BIN_W(BIN_W)) lif ();

    vga_digit_writer #(
        .BIN_W   (BIN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
        .vga_v_sync (vsync),
        .registrotd (td),
        .registrotu (tu),
        .registrosd (sd),
        .registrosu (su),
        .registrosc (sc),
        .saturated  (sat),
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A load occupies the writer from its transfer edge (age 0). Conversions
    // fill ages 1..14; from age 15 on, the first edge that sees vsync go
    // 1 -> 0 (compared with the previous edge's sample), or age 14+TIMEOUT,
    // publishes the decimal digits of the clamped values.
    bit m_busy, m_vsq, m_fall, m_st, m_ss;
    int m_age, m_t, m_s, m_c;
    int e_td, e_tu, e_sd, e_su, e_sc, e_sat, e_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_vsq = 1; m_age = 0;
            e_td = 0; e_tu = 0; e_sd = 0; e_su = 0; e_sc = 0; e_sat = 0; e_done = 0;
        end else begin
            m_fall = m_vsq && !vsync;
            e_done = 0;
            if (!m_busy) begin
                if (lif.load_valid) begin
                    m_t = int'(lif.temp_bin);
                    m_s = int'(lif.set_bin);
                    m_c = int'(lif.status_code);
                    m_st = (m_t > 99); if (m_st) m_t = 99;
                    m_ss = (m_s > 99); if (m_ss) m_s = 99;
                    m_busy = 1;
                    m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age >= 15 && (m_fall || m_age == 14 + TIMEOUT)) begin
                    e_td = m_t / 10; e_tu = m_t % 10;
                    e_sd = m_s / 10; e_su = m_s % 10;
                    e_sc = m_c;
                    e_sat = (m_st || m_ss) ? 1 : 0;
                    e_done = 1;
                    m_busy = 0;
                end
            end
            m_vsq = vsync;
        end
    end

    // One compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("tens_t",  int'(td),  e_td);
        chk("units_t", int'(tu),  e_tu);
        chk("tens_s",  int'(sd),  e_sd);
        chk("units_s", int'(su),  e_su);
        chk("status",  int'(sc),  e_sc);
        chk("sat",     int'(sat), e_sat);
        chk("done",    int'(done), e_done);
        chk("ready",   int'(lif.load_ready), m_busy ? 0 : 1);
    end

    // ---------------- stimulus ----------------
    task automatic load(input int t, input int s, input int c);
        int n;
        n = 0;
        while (!lif.load_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL ready_wait: load_ready stayed 0, expected 1 within 3000 cycles");
        end
        @(negedge clk);
        #1;
        lif.load_valid  = 1'b1;
        lif.temp_bin    = BIN_W'(t);
        lif.set_bin     = BIN_W'(s);
        lif.status_code = 4'(c);
        @(negedge clk);
        #1;
        lif.load_valid = 1'b0;
    endtask

    task automatic pin_digits(input string nm, input int a, input int b, input int c,
                              input int d, input int e, input int s);
        chk({nm, "_td"}, int'(td), a);
        chk({nm, "_tu"}, int'(tu), b);
        chk({nm, "_sd"}, int'(sd), c);
        chk({nm, "_su"}, int'(su), d);
        chk({nm, "_sc"}, int'(sc), e);
        chk({nm, "_sat"}, int'(sat), s);
    endtask

    // After load() returns we sit just past the negedge following the transfer
    // edge (edge 0). This commits with a fall seen at edge k.
    task automatic fall_at(input int k);
        repeat (k - 1) @(negedge clk);
        #1 vsync = 1'b0;
        @(negedge clk);
        #1 vsync = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lif.load_valid  = 1'b0;
        lif.temp_bin    = '0;
        lif.set_bin     = '0;
        lif.status_code = '0;

        // Reset state
        repeat (3) @(negedge clk);
        pin_digits("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(lif.load_ready), 1);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        pin_digits("idle", 0, 0, 0, 0, 0, 0);

        // 37 / 25 / 4, fall seen at edge 40
        load(37, 25, 4);
        repeat (39) @(negedge clk);
        chk("t2_done_before", int'(done), 0);
        pin_digits("t2_before", 0, 0, 0, 0, 0, 0);
        #1 vsync = 1'b0;
        @(negedge clk);
        chk("t2_done", int'(done), 1);
        pin_digits("t2", 3, 7, 2, 5, 4, 0);
        #1 vsync = 1'b1;
        @(negedge clk);
        chk("t2_done_after", int'(done), 0);

        // Clamping
        load(120, 99, 1);
        fall_at(20);
        pin_digits("t3a", 9, 9, 9, 9, 1, 1);
        load(5, 0, 2);
        fall_at(20);
        pin_digits("t3b", 0, 5, 0, 0, 2, 0);

        // Fall during conversion is ignored
        load(64, 8, 3);
        repeat (4) @(negedge clk);
        #1 vsync = 1'b0;
        @(negedge clk);
        #1 vsync = 1'b1;
        chk("t4_early_done", int'(done), 0);
        repeat (54) @(negedge clk);
        chk("t4_done_59", int'(done), 0);
        pin_digits("t4_hold", 0, 5, 0, 0, 2, 0);
        #1 vsync = 1'b0;
        @(negedge clk);
        chk("t4_done_60", int'(done), 1);
        pin_digits("t4", 6, 4, 0, 8, 3, 0);
        #1 vsync = 1'b1;

        // Timeout with vsync held high
        load(42, 17, 9);
        repeat (1013) @(negedge clk);
        chk("t5_done_1013", int'(done), 0);
        @(negedge clk);
        chk("t5_done_1014", int'(done), 1);
        pin_digits("t5", 4, 2, 1, 7, 9, 0);
        @(negedge clk);
        chk("t5_done_1015", int'(done), 0);

        // Valid ignored while busy, reset aborts
        load(11, 22, 5);
        fall_at(20);
        pin_digits("t6a", 1, 1, 2, 2, 5, 0);
        load(88, 77, 6);
        repeat (20) @(negedge clk);
        #1;
        lif.load_valid = 1'b1;
        lif.temp_bin   = 7'd33;
        lif.set_bin    = 7'd44;
        repeat (3) @(negedge clk);
        chk("t6_ready_busy", int'(lif.load_ready), 0);
        pin_digits("t6_hold", 1, 1, 2, 2, 5, 0);
        #1 rst = 1'b0;
        #1;
        pin_digits("t6_rst", 0, 0, 0, 0, 0, 0);
        chk("t6_rst_ready", int'(lif.load_ready), 1);
        lif.load_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1 vsync = (i % 10) > 4;
        end
        pin_digits("t6_after", 0, 0, 0, 0, 0, 0);
        #1 vsync = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            rst             = ($urandom % 1500) != 0;
            lif.load_valid  = ($urandom % 3) == 0;
            lif.temp_bin    = BIN_W'($urandom_range(0, 127));
            lif.set_bin     = BIN_W'($urandom_range(0, 127));
            lif.status_code = 4'($urandom);
            vsync           = ($urandom % 16) != 0;
        end
        #1;
        rst = 1'b1;
        lif.load_valid = 1'b0;
        vsync = 1'b1;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
